// File: rtl/db_store_buffer.sv
// Store buffer for the multi-cycle CPU data bus: aligns stores into word lanes with
// byte enables, queues them, and drains them to data memory over req/ack.
//
// state  | meaning
// S_IDLE | no write outstanding; launches the head entry when the buffer holds one
// S_WAIT | mem_req high with a stable head entry, waiting for mem_ack
module db_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [AW-1:0]              st_addr,
  input  logic [31:0]                st_data,
  input  logic [1:0]                 st_size,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hazard,
  output logic                       mem_req,
  input  logic                       mem_ack,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       misalign_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] valid_q;
  logic [AW-3:0]    addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];

  logic             aligned;
  logic [31:0]      fmt_data;
  logic [3:0]       fmt_be;
  logic             push_hs;
  logic             push;
  logic             pop;
  logic [AW-1:0]    ld_word;

  assign st_ready = (count < CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_hs  = st_valid && st_ready;
  assign push     = push_hs && aligned;
  assign pop      = (state == S_WAIT) && mem_ack;
  assign ld_word  = ld_addr & {{(AW-2){1'b1}}, 2'b00};

  always_comb begin
    aligned  = 1'b1;
    fmt_data = st_data;
    fmt_be   = 4'b1111;
    case (st_size)
      2'b00: begin
        fmt_data = {4{st_data[7:0]}};
        fmt_be   = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        aligned  = !st_addr[0];
        fmt_data = {2{st_data[15:0]}};
        fmt_be   = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: aligned = (st_addr[1:0] == 2'b00);
    endcase
  end

  // In-flight entry keeps its valid bit until acked, so it still counts as a hazard.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ({addr_q[i], 2'b00} == ld_word)) ld_hazard = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      valid_q      <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= push_hs && !aligned;
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      addr_q[wr_ptr] <= st_addr[AW-1:2];
      data_q[wr_ptr] <= fmt_data;
      be_q[wr_ptr]   <= fmt_be;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            mem_addr  <= {addr_q[rd_ptr], 2'b00};
            mem_wdata <= data_q[rd_ptr];
            mem_be    <= be_q[rd_ptr];
            mem_req   <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
